// File: rtl/bitmap_encoder_64x6.sv
`default_nettype none
// ============================================================================
// Module   : bitmap_encoder_64x6
// Purpose  : Sequential 64-to-6 encoder. Captures a 64-bit request bitmap and
//            streams the 6-bit index of every set bit, one index per accepted
//            output beat. Lowest index first by default.
// Revision : 1.0 - initial release
//
// Ports
//   clk          in   1   single clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   in_valid_i   in   1   bitmap offered
//   in_ready_o   out  1   block can accept a bitmap (IDLE only)
//   in_i         in   64  request bitmap, sampled on in_valid_i && in_ready_o
//   abort_i      in   1   synchronous flush of the pending bitmap
//   out_valid_o  out  1   out_idx_o holds a valid index
//   out_ready_i  in   1   consumer takes out_idx_o
//   out_idx_o    out  6   index of the current set bit (0 when not valid)
//   out_last_o   out  1   current index is the final set bit of the bitmap
//   empty_o      out  1   one-cycle pulse: an all-zero bitmap was accepted
//
// Configuration
//   ENC_MSB_FIRST_EN : when defined, indices stream highest set bit first.
// ============================================================================
module bitmap_encoder_64x6 #(
    parameter int SIZE_IN  = 64,
    parameter int SIZE_OUT = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [SIZE_IN-1:0]  in_i,
    input  logic                abort_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [SIZE_OUT-1:0] out_idx_o,
    output logic                out_last_o,
    output logic                empty_o
);

    localparam logic [SIZE_IN-1:0] C_ONE = {{(SIZE_IN-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SIZE_IN-1:0]  pend_q,  pend_d;
    logic                empty_q, empty_d;

    logic [SIZE_OUT-1:0] w_scan_idx;
    logic                w_single;
    logic                w_emit;
    logic [SIZE_IN-1:0]  w_clear_mask;

    // ------------------------------------------------------------------------
    // Priority scan of the pending bitmap. The loop runs so that the winning
    // bit is the one assigned last.
    // ------------------------------------------------------------------------
    always_comb begin
        w_scan_idx = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < SIZE_IN; i++) begin
            if (pend_q[i]) begin
                w_scan_idx = SIZE_OUT'(i);
            end
        end
`else
        for (int i = SIZE_IN - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                w_scan_idx = SIZE_OUT'(i);
            end
        end
`endif
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_single     = (pend_q != '0) && ((pend_q & (pend_q - C_ONE)) == '0);
    assign w_emit       = (state_q == EMIT);
    assign w_clear_mask = C_ONE << w_scan_idx;

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = w_emit;
    assign out_idx_o   = w_emit ? w_scan_idx : '0;
    assign out_last_o  = w_emit & w_single;
    assign empty_o     = empty_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        empty_d = 1'b0;

        case (state_q)
            IDLE: begin
                // abort wins over an offered bitmap: nothing captured, no pulse
                if (!abort_i && in_valid_i) begin
                    if (in_i != '0) begin
                        pend_d  = in_i;
                        state_d = EMIT;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                // abort wins over a simultaneous beat; that beat is dropped
                if (abort_i) begin
                    pend_d  = '0;
                    state_d = IDLE;
                end else if (out_ready_i) begin
                    pend_d = pend_q & ~w_clear_mask;
                    if (w_single) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                pend_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            empty_q <= empty_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bitmap_encoder_64x6.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitmap_encoder_64x6
// Purpose  : Self-checking bench for bitmap_encoder_64x6. A table of bitmaps
//            with expected beat count / first / final index, a scoreboard
//            queue of expected indices, and hand sequences for reset, stall
//            and abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitmap_encoder_64x6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_bm;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        empty;

    always #5 clk = ~clk;

    bitmap_encoder_64x6 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_i        (in_bm),
        .abort_i     (abort),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_idx_o   (out_idx),
        .out_last_o  (out_last),
        .empty_o     (empty)
    );

    typedef struct {
        logic [5:0] idx;
        logic       last;
    } beat_t;

    typedef struct {
        logic [63:0] bm;
        int          beats;
        logic [5:0]  first_idx;
        logic [5:0]  fin_idx;
    } vec_t;

    beat_t      sb[$];
    vec_t       vec[7];
    int         total = 0;
    int         bad   = 0;
    int         beat_cnt = 0;
    logic [5:0] first_seen = '0;
    logic [5:0] fin_seen   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected index stream for a bitmap, in scan order.
    task automatic push_model(input logic [63:0] bm);
        beat_t b;
        int    n = 0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 63; i >= 0; i--) begin
`else
        for (int i = 0; i < 64; i++) begin
`endif
            if (bm[i]) begin
                b.idx  = 6'(i);
                b.last = 1'b0;
                sb.push_back(b);
                n++;
            end
        end
        if (n > 0) sb[sb.size()-1].last = 1'b1;
    endtask

    // Offer a bitmap for one cycle; returns #1 after the capturing edge.
    task automatic send(input logic [63:0] bm);
        push_model(bm);
        in_valid = 1'b1;
        in_bm    = bm;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_bm    = '0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (!in_ready && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Scoreboard monitor: a beat is taken at the next rising edge.
    always @(negedge clk) begin
        beat_t e;
        if (!out_valid) check("idx_zero_when_invalid", 64'(out_idx), 64'd0);
        if (rst_n && out_valid && out_ready && !abort) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got idx %0d expected no beat (t=%0t)", out_idx, $time);
            end else begin
                e = sb.pop_front();
                check("beat_idx",  64'(out_idx),  64'(e.idx));
                check("beat_last", 64'(out_last), 64'(e.last));
            end
            beat_cnt++;
            if (beat_cnt == 1) first_seen = out_idx;
            if (out_last) fin_seen = out_idx;
        end
    end

    initial begin
        int cyc;
        logic [5:0] stall_idx;

`ifdef ENC_MSB_FIRST_EN
        vec[0] = '{64'h8000_0000_0000_0011,  3, 6'd63, 6'd0};
        vec[1] = '{64'h0000_0000_0000_0001,  1, 6'd0,  6'd0};
        vec[2] = '{64'h8000_0000_0000_0000,  1, 6'd63, 6'd63};
        vec[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 6'd63, 6'd0};
        vec[4] = '{64'h0000_0000_0000_0006,  2, 6'd2,  6'd1};
        vec[5] = '{64'hA5A5_0000_0000_0100,  9, 6'd63, 6'd8};
        vec[6] = '{64'h0000_0000_0000_0000,  0, 6'd0,  6'd0};
        stall_idx = 6'd2;
`else
        vec[0] = '{64'h8000_0000_0000_0011,  3, 6'd0,  6'd63};
        vec[1] = '{64'h0000_0000_0000_0001,  1, 6'd0,  6'd0};
        vec[2] = '{64'h8000_0000_0000_0000,  1, 6'd63, 6'd63};
        vec[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 6'd0,  6'd63};
        vec[4] = '{64'h0000_0000_0000_0006,  2, 6'd1,  6'd2};
        vec[5] = '{64'hA5A5_0000_0000_0100,  9, 6'd8,  6'd63};
        vec[6] = '{64'h0000_0000_0000_0000,  0, 6'd0,  6'd0};
        stall_idx = 6'd1;
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bm     = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_idx",   64'(out_idx),   64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_empty",     64'(empty),     64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < 7; v++) begin
            beat_cnt  = 0;
            out_ready = 1'b1;
            send(vec[v].bm);
            check("accept_out_valid", 64'(out_valid), 64'(vec[v].beats != 0));
            check("accept_in_ready",  64'(in_ready),  64'(vec[v].beats == 0));
            check("accept_empty",     64'(empty),     64'(vec[v].beats == 0));
            if (vec[v].beats == 0) begin
                @(posedge clk); #1;
                check("empty_one_cycle", 64'(empty),     64'd0);
                check("empty_no_valid",  64'(out_valid), 64'd0);
            end else begin
                wait_idle(cyc);
                check("drain_cycles", 64'(cyc),        64'(vec[v].beats));
                check("beat_count",   64'(beat_cnt),   64'(vec[v].beats));
                check("first_idx",    64'(first_seen), 64'(vec[v].first_idx));
                check("final_idx",    64'(fin_seen),   64'(vec[v].fin_idx));
            end
            check("sb_drained", 64'(sb.size()), 64'd0);
        end

        // ---------------- reset mid-EMIT ----------------
        beat_cnt  = 0;
        out_ready = 1'b1;
        send(64'hF0);
        @(posedge clk); #1;               // one beat consumed
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_idx",   64'(out_idx),   64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_beats",     64'(beat_cnt),  64'd1);
        check("midrst_idle",      64'(in_ready),  64'd1);
        check("midrst_no_valid",  64'(out_valid), 64'd0);

        // ---------------- stall with out_ready low ----------------
        beat_cnt  = 0;
        out_ready = 1'b0;
        send(64'h6);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_idx",   64'(out_idx),   64'(stall_idx));
            check("stall_last",  64'(out_last),  64'd0);
            in_valid = 1'b1;              // must be ignored while busy
            in_bm    = 64'hFFFF;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        in_bm     = '0;
        out_ready = 1'b1;
        wait_idle(cyc);
        check("stall_drain", 64'(cyc),      64'd2);
        check("stall_beats", 64'(beat_cnt), 64'd2);

        // ---------------- abort on second beat ----------------
        beat_cnt  = 0;
        out_ready = 1'b1;
        send(64'h0F);
        @(posedge clk); #1;               // first beat consumed
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_beats",     64'(beat_cnt),  64'd1);
        sb.delete();
        beat_cnt = 0;
        send(64'h100);
        wait_idle(cyc);
        check("post_abort_beats", 64'(beat_cnt), 64'd1);
        check("post_abort_idx",   64'(fin_seen), 64'd8);

        // ---------------- abort in IDLE beats in_valid ----------------
        abort    = 1'b1;
        in_valid = 1'b1;
        in_bm    = '0;
        @(posedge clk); #1;
        check("idle_abort_no_empty", 64'(empty), 64'd0);
        in_bm = 64'h5;
        @(posedge clk); #1;
        check("idle_abort_no_capture", 64'(out_valid), 64'd0);
        check("idle_abort_ready",      64'(in_ready),  64'd1);
        abort    = 1'b0;
        in_valid = 1'b0;
        in_bm    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
